// File: rtl/apb_event_completer.sv
// APB completer for event-reporting writes.
// Three events (A/B/C) each own a DATA register and a COUNT register. A committed
// DATA write stores the data, bumps a saturating counter and fires a one-cycle pulse.
// A COUNT write clears the counter. Unmapped accesses answer with PSLVERR.
module apb_event_completer #(
  parameter int unsigned WAIT_CYCLES = 0,  // access-phase wait states, 0..15
  parameter int unsigned CNT_W       = 16  // counter width, 1..32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             apb_psel_i,
  input  logic             apb_penable_i,
  input  logic [31:0]      apb_paddr_i,
  input  logic             apb_pwrite_i,
  input  logic [31:0]      apb_pwdata_i,
  output logic [31:0]      apb_prdata_o,
  output logic             apb_pready_o,
  output logic             apb_pslverr_o,
  output logic             event_a_o,
  output logic             event_b_o,
  output logic             event_c_o,
  output logic [31:0]      last_a_o,
  output logic [31:0]      last_b_o,
  output logic [31:0]      last_c_o,
  output logic [CNT_W-1:0] count_a_o,
  output logic [CNT_W-1:0] count_b_o,
  output logic [CNT_W-1:0] count_c_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  localparam logic [31:0] AddrA = 32'hABBA_0000;
  localparam logic [31:0] AddrB = 32'hBAFF_0000;
  localparam logic [31:0] AddrC = 32'hCAFE_0000;

  logic [0:0]       state_q;
  logic [3:0]       wait_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             write_q;
  logic [31:0]      last_q  [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [2:0]       event_q;

  logic [2:0] data_hit;
  logic [2:0] cnt_hit;
  logic       mapped;
  logic       complete;
  logic       commit_wr;

  // Decode the address latched in the setup phase; the live bus address is never used.
  always_comb begin
    data_hit = {addr_q == AddrC, addr_q == AddrB, addr_q == AddrA};
    cnt_hit  = {addr_q == (AddrC | 32'h4), addr_q == (AddrB | 32'h4),
                addr_q == (AddrA | 32'h4)};
    mapped    = |{data_hit, cnt_hit};
    complete  = (state_q == StAccess) && (wait_q == 4'd0) && apb_psel_i && apb_penable_i;
    commit_wr = complete && write_q && mapped;
  end

  // Transfer FSM: setup latches the request, access counts down the wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (apb_psel_i && !apb_penable_i) begin
            state_q <= StAccess;
            wait_q  <= 4'(WAIT_CYCLES);
            addr_q  <= apb_paddr_i;
            wdata_q <= apb_pwdata_i;
            write_q <= apb_pwrite_i;
          end
        end
        StAccess: begin
          if (!apb_psel_i) begin
            // Aborted transfer: drop it without committing anything.
            state_q <= StIdle;
          end else if (apb_penable_i) begin
            if (wait_q != 4'd0) begin
              wait_q <= wait_q - 4'd1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-event registers and pulses, updated only on the completing edge of a mapped write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        last_q[i] <= 32'd0;
        cnt_q[i]  <= '0;
      end
    end else begin
      event_q <= commit_wr ? data_hit : 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (commit_wr && data_hit[i]) begin
          last_q[i] <= wdata_q;
          if (cnt_q[i] != {CNT_W{1'b1}}) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else if (commit_wr && cnt_hit[i]) begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Response: read data and error are only driven during the completing cycle.
  always_comb begin
    apb_prdata_o = 32'd0;
    if (complete && !write_q) begin
      for (int i = 0; i < 3; i++) begin
        if (data_hit[i]) apb_prdata_o = last_q[i];
        if (cnt_hit[i])  apb_prdata_o = 32'(cnt_q[i]);
      end
    end
    apb_pready_o  = complete;
    apb_pslverr_o = complete && !mapped;
  end

  assign event_a_o = event_q[0];
  assign event_b_o = event_q[1];
  assign event_c_o = event_q[2];
  assign last_a_o  = last_q[0];
  assign last_b_o  = last_q[1];
  assign last_c_o  = last_q[2];
  assign count_a_o = cnt_q[0];
  assign count_b_o = cnt_q[1];
  assign count_c_o = cnt_q[2];

endmodule

// File: tb/tb_apb_event_completer.sv
// Bench for apb_event_completer: three instances with different wait/counter
// settings share one APB bus; psel is steered to the instance under test.
module tb_apb_event_completer;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  int          sel;

  logic        rdy [3];
  logic        serr[3];
  logic [31:0] rdata[3];
  logic        ev_a[3], ev_b[3], ev_c[3];
  logic [31:0] last_a[3], last_b[3], last_c[3];
  logic [15:0] cnt_a[3], cnt_b[3], cnt_c[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: WAIT=0/CNT_W=16, instance 1: WAIT=3/CNT_W=2, instance 2: WAIT=5/CNT_W=16.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Wt = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    localparam int unsigned Cw = (g == 1) ? 2 : 16;
    logic [Cw-1:0] ca, cb, cc;
    apb_event_completer #(.WAIT_CYCLES(Wt), .CNT_W(Cw)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .apb_psel_i   (psel && (sel == g)),
      .apb_penable_i(penable),
      .apb_paddr_i  (paddr),
      .apb_pwrite_i (pwrite),
      .apb_pwdata_i (pwdata),
      .apb_prdata_o (rdata[g]),
      .apb_pready_o (rdy[g]),
      .apb_pslverr_o(serr[g]),
      .event_a_o    (ev_a[g]),
      .event_b_o    (ev_b[g]),
      .event_c_o    (ev_c[g]),
      .last_a_o     (last_a[g]),
      .last_b_o     (last_b[g]),
      .last_c_o     (last_c[g]),
      .count_a_o    (ca),
      .count_b_o    (cb),
      .count_c_o    (cc)
    );
    assign cnt_a[g] = 16'(ca);
    assign cnt_b[g] = 16'(cb);
    assign cnt_c[g] = 16'(cc);
  end

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    logic [2:0]  pulse;  // {c,b,a}
    int          ev;     // event whose registers are checked afterwards
    logic [31:0] last;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pulses(input int d);
    return {ev_c[d], ev_b[d], ev_a[d]};
  endfunction

  function automatic logic [31:0] get_last(input int d, input int e);
    case (e)
      0:       return last_a[d];
      1:       return last_b[d];
      default: return last_c[d];
    endcase
  endfunction

  function automatic logic [15:0] get_cnt(input int d, input int e);
    case (e)
      0:       return cnt_a[d];
      1:       return cnt_b[d];
      default: return cnt_c[d];
    endcase
  endfunction

  // Full transfer; the bus address/data are scrambled during access to prove latching.
  task automatic do_xfer(input int d, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, output int waits, output logic err,
                         output logic [31:0] rd, output logic [2:0] p1, output logic [2:0] p2);
    @(negedge clk);
    sel = d; psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1; paddr = 32'hDEAD_BEEF; pwdata = 32'h0BAD_F00D;
    #1;
    waits = 0;
    while (!rdy[d] && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!rdy[d]) begin
      errors++;
      $display("FAIL timeout: pready never rose on instance %0d", d);
    end
    err = serr[d];
    rd  = rdata[d];
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1;
    p1 = pulses(d);
    @(negedge clk);
    #1;
    p2 = pulses(d);
  endtask

  initial begin
    int          w;
    logic        e;
    logic [31:0] r;
    logic [2:0]  p1, p2;

    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; sel = 0;

    //       d  addr            wr    wdata         wt err   rdata      pulse   ev last      cnt
    vecs.push_back('{0, 32'hABBA_0000, 1'b1, 32'h5,      0, 1'b0, 32'h0,   3'b001, 0, 32'h5,    16'd1});
    vecs.push_back('{0, 32'hBAFF_0000, 1'b1, 32'h9,      0, 1'b0, 32'h0,   3'b010, 1, 32'h9,    16'd1});
    vecs.push_back('{0, 32'hBAFF_0000, 1'b1, 32'h2,      0, 1'b0, 32'h0,   3'b010, 1, 32'h2,    16'd2});
    vecs.push_back('{0, 32'hBAFF_0000, 1'b0, 32'h0,      0, 1'b0, 32'h2,   3'b000, 1, 32'h2,    16'd2});
    vecs.push_back('{0, 32'hBAFF_0004, 1'b0, 32'h0,      0, 1'b0, 32'h2,   3'b000, 1, 32'h2,    16'd2});
    vecs.push_back('{0, 32'hBAFF_0004, 1'b1, 32'hFFFF,   0, 1'b0, 32'h0,   3'b000, 1, 32'h2,    16'd0});
    vecs.push_back('{0, 32'h1234_0000, 1'b1, 32'h77,     0, 1'b1, 32'h0,   3'b000, 0, 32'h5,    16'd1});
    vecs.push_back('{0, 32'h1234_0000, 1'b0, 32'h0,      0, 1'b1, 32'h0,   3'b000, 1, 32'h2,    16'd0});
    vecs.push_back('{0, 32'hABBA_0008, 1'b1, 32'h66,     0, 1'b1, 32'h0,   3'b000, 0, 32'h5,    16'd1});
    vecs.push_back('{0, 32'hABBA_0004, 1'b0, 32'h0,      0, 1'b0, 32'h1,   3'b000, 0, 32'h5,    16'd1});
    vecs.push_back('{0, 32'hCAFE_0000, 1'b0, 32'h0,      0, 1'b0, 32'h0,   3'b000, 2, 32'h0,    16'd0});
    vecs.push_back('{1, 32'hCAFE_0000, 1'b1, 32'h7,      3, 1'b0, 32'h0,   3'b100, 2, 32'h7,    16'd1});
    vecs.push_back('{1, 32'hABBA_0000, 1'b1, 32'h1,      3, 1'b0, 32'h0,   3'b001, 0, 32'h1,    16'd1});
    vecs.push_back('{1, 32'hABBA_0000, 1'b1, 32'h2,      3, 1'b0, 32'h0,   3'b001, 0, 32'h2,    16'd2});
    vecs.push_back('{1, 32'hABBA_0000, 1'b1, 32'h3,      3, 1'b0, 32'h0,   3'b001, 0, 32'h3,    16'd3});
    vecs.push_back('{1, 32'hABBA_0000, 1'b1, 32'h4,      3, 1'b0, 32'h0,   3'b001, 0, 32'h4,    16'd3});
    vecs.push_back('{1, 32'hABBA_0004, 1'b0, 32'h0,      3, 1'b0, 32'h3,   3'b000, 0, 32'h4,    16'd3});
    vecs.push_back('{2, 32'hABBA_0000, 1'b1, 32'h11,     5, 1'b0, 32'h0,   3'b001, 0, 32'h11,   16'd1});

    // Reset state of every instance.
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset%0d ready/err/pulse", d), {28'd0, rdy[d], serr[d], pulses(d)}, 32'd0);
      chk($sformatf("reset%0d prdata", d), rdata[d], 32'd0);
      chk($sformatf("reset%0d last", d), last_a[d] | last_b[d] | last_c[d], 32'd0);
      chk($sformatf("reset%0d count", d), {16'd0, cnt_a[d] | cnt_b[d] | cnt_c[d]}, 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_xfer(vecs[i].d, vecs[i].addr, vecs[i].wr, vecs[i].wdata, w, e, r, p1, p2);
      chk($sformatf("v%0d waits", i), w, vecs[i].waits);
      chk($sformatf("v%0d pslverr", i), {31'd0, e}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d prdata", i), r, vecs[i].rdata);
      chk($sformatf("v%0d pulse", i), {29'd0, p1}, {29'd0, vecs[i].pulse});
      chk($sformatf("v%0d pulse_end", i), {29'd0, p2}, 32'd0);
      chk($sformatf("v%0d last", i), get_last(vecs[i].d, vecs[i].ev), vecs[i].last);
      chk($sformatf("v%0d count", i), {16'd0, get_cnt(vecs[i].d, vecs[i].ev)},
          {16'd0, vecs[i].cnt});
      if (i == 0) begin
        chk("v0 b/c untouched", last_b[0] | last_c[0] | {16'd0, cnt_b[0] | cnt_c[0]}, 32'd0);
      end
    end

    // Abort: psel drops after one access cycle on the WAIT=3 instance.
    @(negedge clk);
    sel = 1; psel = 1'b1; penable = 1'b0; paddr = 32'hABBA_0000; pwrite = 1'b1; pwdata = 32'h99;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    p1 = 3'b000;
    repeat (6) begin
      @(negedge clk);
      #1;
      p1 |= pulses(1);
    end
    chk("abort pulse", {29'd0, p1}, 32'd0);
    chk("abort last", last_a[1], 32'h4);
    chk("abort count", {16'd0, cnt_a[1]}, 32'd3);

    // Reset during the 2nd access cycle of the WAIT=5 instance.
    @(negedge clk);
    sel = 2; psel = 1'b1; penable = 1'b0; paddr = 32'hABBA_0000; pwrite = 1'b1; pwdata = 32'h55;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset ready/err/pulse", {28'd0, rdy[2], serr[2], pulses(2)}, 32'd0);
    chk("midreset last_a", last_a[2], 32'd0);
    chk("midreset count_a", {16'd0, cnt_a[2]}, 32'd0);
    chk("midreset other instance", last_a[1], 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after reset pulse", {29'd0, pulses(2)}, 32'd0);
    do_xfer(2, 32'hABBA_0000, 1'b1, 32'h22, w, e, r, p1, p2);
    chk("fresh waits", w, 5);
    chk("fresh pulse", {29'd0, p1}, 32'd1);
    chk("fresh last", last_a[2], 32'h22);
    chk("fresh count", {16'd0, cnt_a[2]}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
